p4_stim_checker: RTL

- Synthesizable traffic generator and checker for the P4 adder port: drives a, b and cin toward the adder, samples sum_dut and cout, and compares them with an internally computed golden result.
- Sits on the other side of the p4_port modport, so the adder can be exercised in hardware or in self-checking simulation without a behavioural testbench.
- Issues one vector per clock and tolerates a pipelined adder through a configurable result latency.

---
 rtl/p4_stim_checker.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/p4_stim_checker.sv
// Self-checking traffic source for the P4 adder: issues directed then LFSR vectors,
// recomputes the sum locally and compares it against the adder after DUT_LATENCY cycles.
module p4_stim_checker #(
    parameter int          NBITS       = 32,
    parameter int          NUM_VECTORS = 256,
    parameter int          DUT_LATENCY = 0,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [NBITS-1:0] a,
    output logic [NBITS-1:0] b,
    output logic             cin,
    input  logic [NBITS-1:0] sum_dut,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      vec_count,
    output logic             first_err_valid,
    output logic [15:0]      first_err_idx,
    output logic [1:0]       dbg_state
);

    // dbg_state encoding: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    localparam logic [31:0]      SEED_INIT  = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0]      LFSR_MASK  = 32'h8020_0003;
    localparam logic [31:0]      PAT_5      = 32'h5555_5555;
    localparam logic [31:0]      PAT_A      = 32'hAAAA_AAAA;
    localparam logic [NBITS-1:0] ONES       = '1;
    localparam logic [15:0]      LAST_IDX   = 16'(NUM_VECTORS - 1);
    localparam logic [2:0]       DRAIN_LAST = (DUT_LATENCY > 0) ? 3'(DUT_LATENCY - 1) : 3'd0;

    state_t state, state_next;

    logic [31:0]      lfsr;
    logic [31:0]      lfsr_rot;
    logic [31:0]      lfsr_adv;
    logic [2:0]       drain_cnt;
    logic             start_run;
    logic             enter_done;
    logic [15:0]      gen_idx;
    logic [NBITS-1:0] gen_a;
    logic [NBITS-1:0] gen_b;
    logic             gen_cin;
    logic             gen_rand;
    logic [NBITS:0]   exp_full;
    logic             cur_valid;
    logic             cmp_valid;
    logic [NBITS:0]   cmp_exp;
    logic [15:0]      cmp_idx;
    logic             mismatch;
    logic [15:0]      err_next;

    assign start_run  = start && ((state == IDLE) || (state == DONE));
    assign enter_done = (state_next == DONE) && (state != DONE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = RUN;
            RUN:   if (vec_count == LAST_IDX) state_next = (DUT_LATENCY > 0) ? DRAIN : DONE;
            DRAIN: if (drain_cnt == DRAIN_LAST) state_next = DONE;
            DONE:  if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN) || (state == DRAIN);
        done      = (state == DONE);
        dbg_state = state;
    end

    // ---------------- vector generation ----------------
    // The loaded vector is always the one after the one on the outputs; vector 0 loads on start.
    assign gen_idx  = start_run ? 16'd0 : vec_count + 16'd1;
    assign lfsr_rot = {lfsr[24:0], lfsr[31:25]};
    assign lfsr_adv = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'h0);

    always_comb begin
        gen_a    = '0;
        gen_b    = '0;
        gen_cin  = 1'b0;
        gen_rand = 1'b0;
        case (gen_idx)
            16'd0: ;
            16'd1: begin gen_a = ONES; gen_cin = 1'b1; end
            16'd2: begin gen_a = ONES; gen_b = ONES; gen_cin = 1'b1; end
            16'd3: begin gen_a = PAT_5[NBITS-1:0]; gen_b = PAT_A[NBITS-1:0]; end
            default: begin
                gen_a    = lfsr[NBITS-1:0];
                gen_b    = ~lfsr_rot[NBITS-1:0];
                gen_cin  = lfsr[31] ^ lfsr[0];
                gen_rand = 1'b1;
            end
        endcase
    end

    // ---------------- golden model and alignment ----------------
    assign exp_full  = {1'b0, a} + {1'b0, b} + {{NBITS{1'b0}}, cin};
    assign cur_valid = (state == RUN);

    generate
        if (DUT_LATENCY == 0) begin : g_direct
            assign cmp_valid = cur_valid;
            assign cmp_exp   = exp_full;
            assign cmp_idx   = vec_count;
        end else begin : g_delay
            logic [DUT_LATENCY-1:0] pipe_valid;
            logic [NBITS:0]         pipe_exp [DUT_LATENCY];
            logic [15:0]            pipe_idx [DUT_LATENCY];

            always_ff @(posedge clk) begin
                if (rst || start_run) begin
                    pipe_valid <= '0;
                end else begin
                    pipe_valid[0] <= cur_valid;
                    for (int k = 1; k < DUT_LATENCY; k++) pipe_valid[k] <= pipe_valid[k-1];
                end
                pipe_exp[0] <= exp_full;
                pipe_idx[0] <= vec_count;
                for (int k = 1; k < DUT_LATENCY; k++) begin
                    pipe_exp[k] <= pipe_exp[k-1];
                    pipe_idx[k] <= pipe_idx[k-1];
                end
            end

            assign cmp_valid = pipe_valid[DUT_LATENCY-1];
            assign cmp_exp   = pipe_exp[DUT_LATENCY-1];
            assign cmp_idx   = pipe_idx[DUT_LATENCY-1];
        end
    endgenerate

    assign mismatch = cmp_valid && busy &&
                      ((sum_dut != cmp_exp[NBITS-1:0]) || (cout != cmp_exp[NBITS]));
    assign err_next = (mismatch && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a               <= '0;
            b               <= '0;
            cin             <= 1'b0;
            lfsr            <= SEED_INIT;
            vec_count       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            pass            <= 1'b0;
            drain_cnt       <= '0;
        end else if (start_run) begin
            a               <= gen_a;
            b               <= gen_b;
            cin             <= gen_cin;
            lfsr            <= SEED_INIT;
            vec_count       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            pass            <= 1'b0;
            drain_cnt       <= '0;
        end else begin
            if (state == RUN) begin
                vec_count <= vec_count + 16'd1;
                if (vec_count != LAST_IDX) begin
                    a   <= gen_a;
                    b   <= gen_b;
                    cin <= gen_cin;
                    if (gen_rand) lfsr <= lfsr_adv;
                end
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
            err_count <= err_next;
            if (mismatch && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_idx   <= cmp_idx;
            end
            if (enter_done) pass <= (err_next == 16'd0);
        end
    end

endmodule
